// File: rtl/instr_encoder.sv
// instr_encoder: turns RISC-V style field sets into 32-bit instruction words.
// Each accepted word is tagged with a running byte address and an error flag,
// then queued in a small FIFO for the consumer.
// Optional feature: define ENC_RANGE_CHECK_EN to flag immediates that do not
// fit their encoding. The encoded bits are the same with or without it.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // Immediate fit tests; with range checking off every immediate "fits".
  logic ok_i;  // 12-bit sign extension (I and S forms)
  logic ok_b;  // 13-bit signed, even (branches)
  logic ok_j;  // 21-bit signed, even (JAL)
  logic ok_u;  // low 12 bits clear (LUI / AUIPC)

`ifdef ENC_RANGE_CHECK_EN
  assign ok_i = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign ok_b = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
  assign ok_j = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
  assign ok_u = ~(|in_imm[11:0]);
`else
  assign ok_i = 1'b1;
  assign ok_b = 1'b1;
  assign ok_j = 1'b1;
  assign ok_u = 1'b1;
`endif

  logic [31:0] enc_instr;
  logic        enc_err;

  // Encode the presented fields by opcode; unknown opcodes become a flagged NOP.
  // NOTE: both outputs get a default before the case so no latch is inferred.
  always_comb begin
    enc_instr = NOP_WORD;
    enc_err   = 1'b1;
    case (in_op)
      OP_R: begin
        enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_op};
        enc_err   = 1'b0;
      end
      OP_IMM, OP_JALR, OP_LOAD: begin
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
        enc_err   = ~ok_i;
      end
      OP_STORE: begin
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op};
        enc_err   = ~ok_i;
      end
      OP_BR: begin
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_op};
        enc_err   = ~ok_b;
      end
      OP_JAL: begin
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op};
        enc_err   = ~ok_j;
      end
      OP_LUI, OP_AUIPC: begin
        enc_instr = {in_imm[31:12], in_rd, in_op};
        enc_err   = ~ok_u;
      end
      default: ;
    endcase
  end

  // Output queue state.
  logic [31:0]      instr_mem [FIFO_DEPTH];
  logic [31:0]      addr_mem  [FIFO_DEPTH];
  logic             err_mem   [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      addr_cnt;
  logic             full;
  logic             push;
  logic             pop;

  // Ready depends only on occupancy, never on out_ready, and is held low in reset.
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign in_ready  = ~rst & ~full;
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Head outputs read as zero whenever the queue is empty.
  assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;
  assign out_addr  = out_valid ? addr_mem[rd_ptr]  : '0;
  assign out_err   = out_valid ? err_mem[rd_ptr]   : 1'b0;

  // Pointer, occupancy and address-counter bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      addr_cnt <= BASE_ADDR;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        addr_cnt <= addr_cnt + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Write the accepted word into the slot at the write pointer.
  // NOTE: the storage array has no reset; emptiness is tracked by count and
  // the head outputs are masked while empty, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= enc_instr;
      addr_mem[wr_ptr]  <= addr_cnt;
      err_mem[wr_ptr]   <= enc_err;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a queue-based model predicts every
// head word; directed cases pin known encodings, backpressure and reset.
module tb_instr_encoder;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_op = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;

  always #5 clk = ~clk;

  instr_encoder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_addr = BASE;

  // Reference encoding built from bit arithmetic on the field values.
  function automatic ent_t model_word(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [2:0] f3, input logic [6:0] f7,
                                      input logic [31:0] imm, input logic [31:0] addr);
    ent_t        e;
    longint      s;
    logic [31:0] w;
    logic        range_bad;
    logic [31:0] common;
    s = longint'($signed(imm));
    common = 32'(op) | (32'(f3) << 12) | (32'(rs1) << 15);
    range_bad = 1'b0;
    e.err = 1'b0;
    case (op)
      7'h33: w = common | (32'(rd) << 7) | (32'(rs2) << 20) | (32'(f7) << 25);
      7'h13, 7'h67, 7'h03: begin
        w = common | (32'(rd) << 7) | ((imm & 32'hFFF) << 20);
        range_bad = (s < -2048) || (s > 2047);
      end
      7'h23: begin
        w = common | (32'(rs2) << 20) | ((imm & 32'h1F) << 7) | (((imm >> 5) & 32'h7F) << 25);
        range_bad = (s < -2048) || (s > 2047);
      end
      7'h63: begin
        w = common | (32'(rs2) << 20) | (((imm >> 11) & 1) << 7) | (((imm >> 1) & 32'hF) << 8)
            | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 1) << 31);
        range_bad = (s < -4096) || (s > 4095) || (imm % 2 != 0);
      end
      7'h6F: begin
        w = 32'(op) | (32'(rd) << 7) | (((imm >> 12) & 32'hFF) << 12) | (((imm >> 11) & 1) << 20)
            | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 20) & 1) << 31);
        range_bad = (s < -1048576) || (s > 1048575) || (imm % 2 != 0);
      end
      7'h37, 7'h17: begin
        w = 32'(op) | (32'(rd) << 7) | (imm & 32'hFFFF_F000);
        range_bad = (imm % 4096 != 0);
      end
      default: begin
        w = 32'h0000_0013;
        e.err = 1'b1;
      end
    endcase
`ifdef ENC_RANGE_CHECK_EN
    e.err = e.err | range_bad;
`endif
    e.instr = w;
    e.addr  = addr;
    return e;
  endfunction

  // Model: track handshakes from its own occupancy, not the DUT's ready.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_addr = BASE;
    end else begin
      automatic bit do_push = in_valid && (q.size() < DEPTH);
      automatic bit do_pop  = out_ready && (q.size() > 0);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(model_word(in_op, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, m_addr));
        m_addr = m_addr + 32'd4;
      end
    end
  end

  // Compare process: every falling edge, DUT outputs against the model.
  always @(negedge clk) begin
    check("in_ready", 32'(in_ready), 32'(!rst && q.size() < DEPTH));
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      check("out_instr", out_instr, q[0].instr);
      check("out_addr", out_addr, q[0].addr);
      check("out_err", 32'(out_err), 32'(q[0].err));
    end else begin
      check("empty_instr", out_instr, 32'h0);
      check("empty_addr", out_addr, 32'h0);
      check("empty_err", 32'(out_err), 32'h0);
    end
  end

  // Present one field set and hold it until accepted; returns 1 ns after the edge.
  task automatic push(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = 7'h00; in_imm = imm;
    in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    check("push_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'h1);
  endtask

  logic [6:0]  op_list [11] = '{7'h33, 7'h13, 7'h67, 7'h03, 7'h23, 7'h63,
                                7'h6F, 7'h37, 7'h17, 7'h7F, 7'h00};
  logic [31:0] got[$];

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;

    // Known encodings, head visible one cycle after the handshake.
    push(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    check("addi_instr", out_instr, 32'h0050_0093);
    check("addi_addr", out_addr, BASE);
    check("addi_err", 32'(out_err), 32'h0);

    push(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFF_FFF8);
    check("beq_instr", out_instr, 32'hFE20_8CE3);
    check("beq_err", 32'(out_err), 32'h0);

    push(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0800);
    check("jal_instr", out_instr, 32'h0010_00EF);
    check("jal_err", 32'(out_err), 32'h0);

    push(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0801);
    check("jal_odd_instr", out_instr, 32'h0010_00EF);
`ifdef ENC_RANGE_CHECK_EN
    check("jal_odd_err", 32'(out_err), 32'h1);
`else
    check("jal_odd_err", 32'(out_err), 32'h0);
`endif

    push(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0800);
    check("addi_big_instr", out_instr, 32'h8000_0093);
`ifdef ENC_RANGE_CHECK_EN
    check("addi_big_err", 32'(out_err), 32'h1);
`else
    check("addi_big_err", 32'(out_err), 32'h0);
`endif

    push(7'h7F, 5'd3, 5'd4, 5'd5, 3'd2, 32'h1234_5678);
    check("bad_op_instr", out_instr, 32'h0000_0013);
    check("bad_op_err", 32'(out_err), 32'h1);
    check("bad_op_addr", out_addr, BASE + 32'd20);

    // Backpressure: queue fills at two, ready stays low, then drains in order.
    out_ready = 1'b0;
    do_reset();
    push(7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 32'h0);
    push(7'h33, 5'd4, 5'd5, 5'd6, 3'd1, 32'h0);
    in_op = 7'h33; in_rd = 5'd7; in_imm = 32'h0;
    in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("full_ready", 32'(in_ready), 32'h0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 20 && got.size() < 3; i++) begin
      automatic bit acc;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid) got.push_back(out_addr);
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check("drain_count", 32'(got.size()), 32'd3);
    for (int i = 0; i < 3 && i < got.size(); i++)
      check("drain_addr", got[i], BASE + 32'(4 * i));

    // Reset with two words queued discards them and restarts the address.
    out_ready = 1'b0;
    push(7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 32'd1);
    push(7'h13, 5'd2, 5'd2, 5'd0, 3'd0, 32'd2);
    check("pre_rst_valid", 32'(out_valid), 32'h1);
    do_reset();
    out_ready = 1'b1;
    push(7'h37, 5'd9, 5'd0, 5'd0, 3'd0, 32'hABCD_E000);
    check("post_rst_addr", out_addr, BASE);
    check("lui_instr", out_instr, 32'hABCD_E4B7);

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_op     = op_list[$urandom_range(0, 10)];
      in_rd     = 5'($urandom);
      in_rs1    = 5'($urandom);
      in_rs2    = 5'($urandom);
      in_funct3 = 3'($urandom);
      in_funct7 = 7'($urandom);
      case ($urandom_range(0, 3))
        0: in_imm = 32'($signed($urandom_range(0, 4095)) - 2048);
        1: in_imm = $urandom;
        2: in_imm = 32'($signed($urandom_range(0, 8191)) - 4096) & 32'hFFFF_FFFE;
        default: in_imm = $urandom & 32'hFFFF_F000;
      endcase
    end

    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + 3) @(posedge clk);
    #1;
    check("final_empty", 32'(out_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: address tagged on the first encoded word after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: output queue entries; a power of two, at least 2.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous reset, active-high.
REQ-006 in_valid  in  1  field set presented.
REQ-007 in_ready  out  1  field set accepted this cycle when high with in_valid.
REQ-008 in_op  in  7  opcode.
REQ-009 in_rd, in_rs1, in_rs2  in  5 each  register indices.
REQ-010 in_funct3  in  3; in_funct7  in  7  function fields.
REQ-011 in_imm  in  32  full-width immediate value, two's complement.
REQ-012 out_valid  out  1  queue head valid.
REQ-013 out_ready  in  1  consumer takes the head when high with out_valid.
REQ-014 out_instr  out  32  encoded instruction word.
REQ-015 out_addr  out  32  word address tag.
REQ-016 out_err  out  1  encoding error flag for the head entry.

Function
REQ-017 Encoding SHALL follow the opcode as listed below; every field not listed SHALL come from the matching in_* port.
- 0110011: funct7|rs2|rs1|f3|rd|op
- 0010011, 1100111, 0000011: imm[11:0]|rs1|f3|rd|op
- 0100011: imm[11:5]|rs2|rs1|f3|imm[4:0]|op
- 1100011: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op
- 1101111: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
- 0110111, 0010111: imm[31:12]|rd|op
REQ-018 Any other opcode SHALL encode 32'h0000_0013 with err=1.
REQ-019 in_ready SHALL be high only when the queue is not full; it SHALL NOT depend combinationally on out_ready.
REQ-020 A handshake at edge N SHALL make the entry visible at the head from edge N if the queue was empty, with latency 1 cycle.
REQ-021 Entries SHALL leave in acceptance order.
REQ-022 When empty, out_valid, out_instr, out_addr and out_err SHALL be 0.
REQ-023 Simultaneous push and pop on a non-full queue SHALL keep the occupancy unchanged.
REQ-024 When full, in_ready SHALL be 0 even if a pop occurs in the same cycle.
REQ-025 The address counter SHALL start at BASE_ADDR and add 4 per accepted word, wrapping modulo 2^32.
REQ-026 Each accepted word SHALL carry the counter value before the increment.
REQ-027 Words with err=1 SHALL still be queued and still consume an address.
REQ-028 Head outputs SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-029 rst SHALL asynchronously empty the queue, set the counter to BASE_ADDR, and force every output to 0 (in_ready=0 while rst is high).
REQ-030 A reset mid-operation SHALL discard all queued words.
REQ-031 in_ready SHALL go high in the first cycle after rst deasserts.

Configuration
REQ-032 When ENC_RANGE_CHECK_EN is defined, err SHALL be 1 in each of these cases:
- I- or S-type imm is not a 12-bit sign extension.
- Branch imm is not a 13-bit signed value, or imm[0]=1.
- JAL imm is not a 21-bit signed value, or imm[0]=1.
- LUI or AUIPC imm[11:0] is not 0.
REQ-033 When ENC_RANGE_CHECK_EN is undefined, the immediate SHALL be truncated silently and err SHALL be 1 only for unsupported opcodes.
REQ-034 The encoded bits SHALL be identical in both builds.

Verification
REQ-035 Bench SHALL cover op=0x13, rd=1, rs1=0, f3=0, imm=5 -> out_instr=0x00500093, out_addr=0x0, err=0, one cycle after the handshake.
REQ-036 Bench SHALL cover op=0x63, rs1=1, rs2=2, f3=0, imm=0xFFFFFFF8 -> 0xFE208CE3, err=0.
REQ-037 Bench SHALL cover op=0x6F, rd=1, imm=0x800 -> 0x001000EF; then op=0x6F with imm=0x801 -> err=1 when the macro is defined.
REQ-038 Bench SHALL cover out_ready=0 while pushing 3 words with FIFO_DEPTH=2 -> in_ready=0 after 2 accepts; then raise out_ready -> addresses 0x0, 0x4, 0x8 in order.
REQ-039 Bench SHALL cover op=0x13, imm=0x800 -> with the macro: err=1; without it: 0x80000093, err=0. It SHALL also cover op=0x7F -> 0x00000013, err=1 in both builds.
REQ-040 Bench SHALL cover rst asserted with 2 words queued -> out_valid=0 immediately; the next accepted word has out_addr=BASE_ADDR.
